// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - TCDM request/response types and atomic op helpers for the bank responder
package mempool_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumBanksPerTile  = 16;
  localparam int unsigned TCDMAddrMemWidth = 10;
  localparam int unsigned IniAddrWidth     = 4;
  localparam int unsigned MetaIdWidth      = 5;
  localparam int unsigned CoreIdWidth      = 3;
  localparam int unsigned TgtAddrWidth     = TCDMAddrMemWidth + idx_width(NumBanksPerTile);

  typedef logic [31:0] data_t;
  typedef logic [3:0]  amo_t;

  localparam amo_t AmoNone = 4'd0;
  localparam amo_t AmoSwap = 4'd1;
  localparam amo_t AmoAdd  = 4'd2;
  localparam amo_t AmoAnd  = 4'd3;
  localparam amo_t AmoOr   = 4'd4;
  localparam amo_t AmoXor  = 4'd5;
  localparam amo_t AmoMax  = 4'd6;
  localparam amo_t AmoMaxu = 4'd7;
  localparam amo_t AmoMin  = 4'd8;
  localparam amo_t AmoMinu = 4'd9;

  typedef struct packed {
    amo_t                   amo;
    logic [MetaIdWidth-1:0] meta_id;
    logic [CoreIdWidth-1:0] core_id;
    data_t                  data;
  } tcdm_payload_t;

  typedef struct packed {
    logic [TgtAddrWidth-1:0] tgt_addr;
    logic                    wen;
    logic [3:0]              be;
    tcdm_payload_t           wdata;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_req_t;

  typedef struct packed {
    tcdm_payload_t           rdata;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_resp_t;

  // Unassigned op codes fall through to swap semantics.
  function automatic data_t amo_compute(amo_t op, data_t old, data_t operand);
    case (op)
      AmoAdd:  return old + operand;
      AmoAnd:  return old & operand;
      AmoOr:   return old | operand;
      AmoXor:  return old ^ operand;
      AmoMax:  return ($signed(old) > $signed(operand)) ? old : operand;
      AmoMaxu: return (old > operand) ? old : operand;
      AmoMin:  return ($signed(old) < $signed(operand)) ? old : operand;
      AmoMinu: return (old < operand) ? old : operand;
      default: return operand;
    endcase
  endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// rtl/tcdm_resp_fifo.sv - circular response buffer with occupancy count
module tcdm_resp_fifo
  import mempool_pkg::*;
#(
  parameter  int unsigned Depth    = 2,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push,
  input  tcdm_slave_resp_t    push_data,
  input  logic                pop,
  output logic                valid,
  output tcdm_slave_resp_t    head,
  output logic [CntWidth-1:0] count
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  tcdm_slave_resp_t    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                do_pop;

  assign do_pop = pop && (count_q != '0);
  assign valid  = (count_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      if (push && !do_pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!push && do_pop) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - TCDM target port driving one SRAM bank, with atomics and credited responses
module tcdm_bank_responder
  import mempool_pkg::*;
#(
  parameter int unsigned RespDepth     = 2,
  parameter int unsigned BankAddrWidth = TCDMAddrMemWidth,
  parameter int unsigned BankSelWidth  = idx_width(NumBanksPerTile)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  tcdm_slave_req_t          req_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output tcdm_slave_resp_t         resp_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [BankAddrWidth-1:0] mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [3:0]               mem_be_o,
  input  logic [31:0]              mem_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RespDepth + 1);
  localparam int unsigned OccWidth = CntWidth + 1;
  localparam logic [OccWidth-1:0] Credits = OccWidth'(RespDepth);

  typedef enum logic {Idle, AmoWb} state_e;

  state_e                  state_q;
  logic                    inflight_q;
  tcdm_payload_t           meta_q;
  logic [IniAddrWidth-1:0] ini_addr_q;
  logic [BankAddrWidth-1:0] amo_addr_q;

  logic [CntWidth-1:0]      fifo_count;
  logic [OccWidth-1:0]      occupancy;
  logic                     is_plain_write;
  logic                     is_amo;
  logic                     accept;
  logic [BankAddrWidth-1:0] req_addr;
  tcdm_slave_resp_t         push_data;
  logic                     unused_sel;

  assign unused_sel     = ^req_i.tgt_addr[BankSelWidth-1:0];
  assign is_amo         = (req_i.wdata.amo != AmoNone);
  assign is_plain_write = req_i.wen && !is_amo;
  assign req_addr       = req_i.tgt_addr[BankSelWidth +: BankAddrWidth];

  // Credits count the word already in the bank pipeline, so a read can never find the FIFO full.
  assign occupancy   = OccWidth'(fifo_count) + OccWidth'(inflight_q);
  assign req_ready_o = (state_q == Idle) && (is_plain_write || (occupancy < Credits));
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == AmoWb) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = amo_addr_q;
      mem_wdata_o = amo_compute(meta_q.amo, mem_rdata_i, meta_q.data);
      mem_be_o    = 4'hF;
    end else if (accept) begin
      mem_req_o  = 1'b1;
      mem_we_o   = is_plain_write;
      mem_addr_o = req_addr;
      if (is_plain_write) begin
        mem_wdata_o = req_i.wdata.data;
        mem_be_o    = req_i.be;
      end
    end
  end

  // meta_q.data doubles as the atomic operand; the response data comes from the bank instead.
  always_comb begin
    push_data              = '0;
    push_data.rdata        = meta_q;
    push_data.rdata.data   = mem_rdata_i;
    push_data.ini_addr     = ini_addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      inflight_q <= 1'b0;
      meta_q     <= '0;
      ini_addr_q <= '0;
      amo_addr_q <= '0;
    end else begin
      inflight_q <= accept && !is_plain_write;
      if (accept && !is_plain_write) begin
        meta_q     <= req_i.wdata;
        ini_addr_q <= req_i.ini_addr;
      end
      case (state_q)
        Idle: begin
          if (accept && is_amo) begin
            state_q    <= AmoWb;
            amo_addr_q <= req_addr;
          end
        end
        AmoWb:   state_q <= Idle;
        default: state_q <= Idle;
      endcase
    end
  end

  tcdm_resp_fifo #(
    .Depth(RespDepth)
  ) i_resp_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (inflight_q),
    .push_data(push_data),
    .pop      (resp_ready_i),
    .valid    (resp_valid_o),
    .head     (resp_o),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb/tb_tcdm_bank_responder.sv - bench for tcdm_bank_responder with SRAM model and response scoreboard
module tb_tcdm_bank_responder;
  import mempool_pkg::*;

  localparam int Depth = 2;
  localparam int Bsw   = 4;
  localparam int Baw   = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready_o;
  tcdm_slave_req_t  req;
  logic             resp_valid_o;
  logic             resp_ready;
  tcdm_slave_resp_t resp_o;
  logic             mem_req_o, mem_we_o;
  logic [Baw-1:0]   mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_rdata = '0;

  logic [31:0] sram [0:1023] = '{default: '0};
  logic [31:0] ref_mem [0:1023];
  tcdm_slave_resp_t exp_q [$];
  logic [31:0]      popped [$];

  int checks = 0;
  int failures = 0;
  logic acc;
  logic s_ready, s_mem_req, s_mem_we, s_resp_valid;
  logic [31:0] s_mem_wdata;
  logic [Baw-1:0] s_mem_addr;
  tcdm_slave_resp_t last_resp;

  always #5 clk = ~clk;

  tcdm_bank_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_i       (req),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready),
    .resp_o      (resp_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata)
  );

  // Single-port SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) sram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_amo(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (op == 2) return a + b;
    if (op == 3) return a & b;
    if (op == 4) return a | b;
    if (op == 5) return a ^ b;
    if (op == 6) return (sa >= sb) ? a : b;
    if (op == 7) return (a >= b) ? a : b;
    if (op == 8) return (sa <= sb) ? a : b;
    if (op == 9) return (a <= b) ? a : b;
    return b;
  endfunction

  task automatic model_accept(input tcdm_slave_req_t r);
    int w;
    logic [31:0] old;
    tcdm_slave_resp_t e;
    w = int'(r.tgt_addr[Bsw +: Baw]);
    old = ref_mem[w];
    if (r.wdata.amo == 4'd0 && r.wen) begin
      for (int k = 0; k < 4; k++)
        if (r.be[k]) ref_mem[w][8*k +: 8] = r.wdata.data[8*k +: 8];
    end else begin
      if (r.wdata.amo != 4'd0) ref_mem[w] = ref_amo(r.wdata.amo, old, r.wdata.data);
      e = '0;
      e.rdata.amo = r.wdata.amo;
      e.rdata.meta_id = r.wdata.meta_id;
      e.rdata.core_id = r.wdata.core_id;
      e.rdata.data = old;
      e.ini_addr = r.ini_addr;
      exp_q.push_back(e);
      check("credit_bound", 64'(exp_q.size()), 64'(exp_q.size() <= Depth ? exp_q.size() : Depth));
    end
  endtask

  task automatic model_pop(input tcdm_slave_resp_t r);
    last_resp = r;
    popped.push_back(r.rdata.data);
    if (exp_q.size() == 0) begin
      check("unexpected_resp", 64'(r), 64'(0) ^ 64'(r) ^ 64'hBAD);
    end else begin
      check("resp", 64'(r), 64'(exp_q.pop_front()));
    end
  endtask

  // Inputs are set just after a negedge; outputs are sampled 1 time unit later.
  task automatic tick();
    #1;
    s_ready = req_ready_o;
    s_mem_req = mem_req_o;
    s_mem_we = mem_we_o;
    s_mem_wdata = mem_wdata_o;
    s_mem_addr = mem_addr_o;
    s_resp_valid = resp_valid_o;
    acc = rst_n && req_valid && req_ready_o;
    if (acc) model_accept(req);
    if (rst_n && resp_valid_o && resp_ready) model_pop(resp_o);
    @(negedge clk);
  endtask

  // kind: 0 write, 1 read, 2 atomic
  task automatic set_req(input int kind, input int word, input logic [31:0] data, input logic [3:0] be,
                         input logic [3:0] op, input int ini, input int meta);
    req = '0;
    req.tgt_addr = {10'(word), 4'($urandom_range(0, 15))};
    req.wen = (kind == 0) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    req.be = (kind == 0) ? be : 4'($urandom_range(0, 15));
    req.wdata.amo = (kind == 2) ? op : 4'd0;
    req.wdata.data = data;
    req.wdata.meta_id = 5'(meta);
    req.wdata.core_id = 3'($urandom_range(0, 7));
    req.ini_addr = 4'(ini);
    req_valid = 1'b1;
  endtask

  task automatic issue(input int kind, input int word, input logic [31:0] data, input logic [3:0] be, input logic [3:0] op);
    int budget = 0;
    set_req(kind, word, data, be, op, $urandom_range(0, 15), $urandom_range(0, 31));
    acc = 1'b0;
    while (!acc && budget < 50) begin
      tick();
      budget++;
    end
    if (!acc) check("issue_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (2) tick();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] old;
    logic [31:0] operand;
    logic [31:0] exp_resp;
    logic [31:0] exp_mem;
  } amo_vec_t;

  amo_vec_t vecs [13];

  initial begin
    logic [31:0] saved;
    vecs[0]  = '{4'd2,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{4'd7,  32'h00000001, 32'h80000000, 32'h00000001, 32'h80000000};
    vecs[2]  = '{4'd6,  32'h00000001, 32'h80000000, 32'h00000001, 32'h00000001};
    vecs[3]  = '{4'd9,  32'h00000001, 32'h80000000, 32'h00000001, 32'h00000001};
    vecs[4]  = '{4'd8,  32'h00000001, 32'h80000000, 32'h00000001, 32'h80000000};
    vecs[5]  = '{4'd1,  32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
    vecs[6]  = '{4'd3,  32'hFF00FF00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[7]  = '{4'd4,  32'h000000F0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vecs[8]  = '{4'd5,  32'h12345678, 32'hFFFF0000, 32'h12345678, 32'hEDCB5678};
    vecs[9]  = '{4'd12, 32'h11111111, 32'h55AA55AA, 32'h11111111, 32'h55AA55AA};
    vecs[10] = '{4'd2,  32'h7FFFFFF8, 32'h00000010, 32'h7FFFFFF8, 32'h80000008};
    vecs[11] = '{4'd8,  32'h00000005, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF};
    vecs[12] = '{4'd9,  32'h00000005, 32'hFFFFFFFF, 32'h00000005, 32'h00000005};

    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready_o), 64'(1));
    check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read latency and metadata passthrough
    issue(0, 5, 32'hDEADBEEF, 4'hF, 4'd0);
    drain();
    set_req(1, 5, 32'h0, 4'h0, 4'd0, 3, 7);
    tick();
    check("lat_accept", 64'(acc), 64'(1));
    check("lat_mem_req", 64'({s_mem_req, s_mem_we}), 64'(2'b10));
    check("lat_mem_addr", 64'(s_mem_addr), 64'(5));
    req_valid = 1'b0;
    tick();
    check("lat_cycle1_valid", 64'(s_resp_valid), 64'(0));
    tick();
    check("lat_cycle2_valid", 64'(s_resp_valid), 64'(1));
    check("lat_data", 64'(last_resp.rdata.data), 64'(32'hDEADBEEF));
    check("lat_ini_meta", 64'({last_resp.ini_addr, last_resp.rdata.meta_id}), 64'({4'd3, 5'd7}));
    drain();

    // Partial byte-enable write
    issue(0, 9, 32'hFFFFFFFF, 4'hF, 4'd0);
    issue(0, 9, 32'h12345678, 4'b0011, 4'd0);
    issue(1, 9, 32'h0, 4'h0, 4'd0);
    drain();
    check("be_merge", 64'(last_resp.rdata.data), 64'(32'hFFFF5678));

    // Backpressure with credits
    issue(0, 10, 32'hA0A0A0A0, 4'hF, 4'd0);
    issue(0, 11, 32'hB1B1B1B1, 4'hF, 4'd0);
    issue(0, 12, 32'hC2C2C2C2, 4'hF, 4'd0);
    drain();
    popped.delete();
    resp_ready = 1'b0;
    set_req(1, 10, 0, 0, 0, 1, 1); tick(); check("bp_acc0", 64'(acc), 64'(1));
    set_req(1, 11, 0, 0, 0, 2, 2); tick(); check("bp_acc1", 64'(acc), 64'(1));
    set_req(1, 12, 0, 0, 0, 3, 3); tick(); check("bp_full", 64'(s_ready), 64'(0));
    tick(); check("bp_full_hold", 64'(s_ready), 64'(0));
    resp_ready = 1'b1;
    tick(); check("bp_no_fwd_credit", 64'({s_ready, s_resp_valid}), 64'(2'b01));
    tick(); check("bp_acc2", 64'(acc), 64'(1));
    drain();
    check("bp_order_n", 64'(popped.size()), 64'(3));
    if (popped.size() == 3)
      check("bp_order", {popped[0][15:0], popped[1][15:0], popped[2][15:0], 16'h0},
            64'hA0A0B1B1C2C20000);

    // Atomic truth table
    for (int i = 0; i < 13; i++) begin
      issue(0, 40 + i, vecs[i].old, 4'hF, 4'd0);
      issue(2, 40 + i, vecs[i].operand, 4'h0, vecs[i].op);
      drain();
      check($sformatf("amo_resp_%0d", i), 64'(last_resp.rdata.data), 64'(vecs[i].exp_resp));
      check($sformatf("amo_mem_%0d", i), 64'(sram[40 + i]), 64'(vecs[i].exp_mem));
    end

    // Atomic then read: stall in AMO_WB, read sees the written value
    issue(0, 20, 32'd5, 4'hF, 4'd0);
    drain();
    set_req(2, 20, 32'd3, 4'h0, 4'd2, 0, 0);
    tick();
    check("amo_rd_acc", 64'(acc), 64'(1));
    set_req(1, 20, 0, 0, 0, 0, 0);
    tick();
    check("amo_wb_stall", 64'({acc, s_ready, s_mem_we}), 64'(3'b001));
    check("amo_wb_wdata", 64'(s_mem_wdata), 64'(32'd8));
    tick();
    check("amo_rd_next", 64'(acc), 64'(1));
    drain();
    check("amo_rd_value", 64'(last_resp.rdata.data), 64'(32'd8));

    // Reset during AMO_WB
    issue(0, 21, 32'h11, 4'hF, 4'd0);
    drain();
    saved = ref_mem[21];
    set_req(2, 21, 32'h99, 4'h0, 4'd1, 0, 0);
    tick();
    check("rst_amo_acc", 64'(acc), 64'(1));
    req_valid = 1'b0;
    #2;
    check("rst_amo_pre_we", 64'(mem_we_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_amo_no_write", 64'({mem_req_o, mem_we_o, resp_valid_o}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    ref_mem[21] = saved;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_amo_no_resp", 64'(s_resp_valid), 64'(0));
    end
    check("rst_amo_mem", 64'(sram[21]), 64'(32'h11));

    // Random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 75)
        set_req($urandom_range(0, 2), 100 + $urandom_range(0, 7), $urandom, 4'($urandom_range(0, 15)),
                4'($urandom_range(1, 15)), $urandom_range(0, 15), $urandom_range(0, 31));
      else
        req_valid = 1'b0;
      resp_ready = ($urandom_range(0, 99) < 65);
      tick();
    end
    drain();
    for (int i = 0; i < 128; i++)
      if (sram[i] !== ref_mem[i]) check($sformatf("mem_%0d", i), 64'(sram[i]), 64'(ref_mem[i]));
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
